// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with a frame-boundary-reloaded digit buffer.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module seven_seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [5*NUM_DIGITS-1:0] DIGITS_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    SCAN_TICK
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BUF_W = 5 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic                  load_pend_q, load_pend_d;
  logic                  adv_q, adv_d;
  logic                  tick_out_q, tick_out_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            hex_q, hex_d;

  logic                  tick_c;
  logic [BUF_W-1:0]      src_c;
  logic [4:0]            cur_c;
  logic                  cur_blank_c;
  logic [NUM_DIGITS-1:0] blank_c;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex value
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // The first enabled cycle displays straight from the input, since the buffer loads on that same edge
  assign src_c = load_pend_q ? DIGITS_IN : buf_q;

`ifdef SEVENSEG_LZ_BLANK_EN
  logic lz_run_c;

  // A digit is blanked while it and every more significant digit are zero; digit 0 always shows
  always_comb begin
    blank_c  = '0;
    lz_run_c = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz_run_c   = lz_run_c && (src_c[5*k +: 4] == 4'h0);
      blank_c[k] = lz_run_c;
    end
  end
`else
  assign blank_c = '0;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    load_pend_d = load_pend_q;
    adv_d       = 1'b0;
    tick_out_d  = adv_q;
    sel_d       = '1;
    hex_d       = 8'hFF;
    tick_c      = 1'b0;
    cur_c       = '0;
    cur_blank_c = 1'b0;

    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_c       = src_c[5*k +: 5];
        cur_blank_c = blank_c[k];
      end
    end

    if (ENABLE) begin
      tick_c      = (cnt_q == CNT_LAST);
      adv_d       = tick_c;
      load_pend_d = 1'b0;
      cnt_d       = tick_c ? '0 : cnt_q + CNT_W'(1);
      if (tick_c) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      if (load_pend_q || (tick_c && (idx_q == IDX_LAST))) begin
        buf_d = DIGITS_IN;
      end
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        sel_d[k] = (idx_q != IDX_W'(k));
      end
      hex_d = {~cur_c[4], cur_blank_c ? 7'h7F : decode7(cur_c[3:0])};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      load_pend_q <= 1'b1;
      adv_q       <= 1'b0;
      tick_out_q  <= 1'b0;
      sel_q       <= '1;
      hex_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      load_pend_q <= load_pend_d;
      adv_q       <= adv_d;
      tick_out_q  <= tick_out_d;
      sel_q       <= sel_d;
      hex_q       <= hex_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;
  assign HEX_OUT        = hex_q;
  assign SCAN_TICK      = tick_out_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4.
// Define SEVENSEG_LZ_BLANK_EN for both bench and design to check leading-zero blanking.
module tb_seven_seg_scan_mux;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [19:0] digits;
  logic [3:0]  seg_sel;
  logic [7:0]  hex;
  logic        scan_tick;

  int n_vec = 0;
  int n_err = 0;

  seven_seg_scan_mux #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .CLK           (clk),
    .RESET         (reset),
    .ENABLE        (enable),
    .DIGITS_IN     (digits),
    .SEG_SELECT_OUT(seg_sel),
    .HEX_OUT       (hex),
    .SCAN_TICK     (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n = sample index after reset release (or enabled-edge index); hexes = {d3,d2,d1,d0}
  task automatic step_check(input int n, input logic [31:0] hexes);
    int         d;
    logic [3:0] es;
    cyc();
    d      = ((n - 1) / 4) % 4;
    es     = 4'hF;
    es[d]  = 1'b0;
    check_val($sformatf("sel[n=%0d]", n), 32'(seg_sel), 32'(es));
    check_val($sformatf("hex[n=%0d]", n), 32'(hex), 32'(hexes[8*d +: 8]));
    check_val($sformatf("tick[n=%0d]", n), 32'(scan_tick), 32'((n > 1) && ((n - 1) % 4 == 0)));
  endtask

  task automatic check_blank(input string tag);
    check_val({tag, "_sel"}, 32'(seg_sel), 32'h0000_000F);
    check_val({tag, "_hex"}, 32'(hex), 32'h0000_00FF);
    check_val({tag, "_tick"}, 32'(scan_tick), 32'h0);
  endtask

  task automatic do_reset(input logic [19:0] val);
    reset  = 1'b1;
    digits = val;
    cyc();
    check_blank("reset");
    reset = 1'b0;
  endtask

  logic [31:0] lz_hex;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    digits = {5'h03, 5'h02, 5'h11, 5'h00};
    cyc();
    cyc();
    check_blank("reset0");
    reset = 1'b0;

    // Basic scan over two frames; mid-frame change while digit 1 is shown
    for (int n = 1; n <= 32; n++) begin
      step_check(n, {8'hB0, 8'hA4, 8'h79, 8'hC0});
      if (n == 21) digits = {4{5'h08}};
    end
    for (int n = 33; n <= 50; n++) step_check(n, 32'h8080_8080);

    // Enable gating mid-slot of digit 0
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_blank($sformatf("dis%0d", i));
    end
    enable = 1'b1;
    for (int n = 51; n <= 57; n++) step_check(n, 32'h8080_8080);

    // Mid-frame reset while digit 2 is displayed, restart with fresh load
    do_reset({5'h0F, 5'h0E, 5'h1A, 5'h0B});
    for (int n = 1; n <= 17; n++) step_check(n, {8'h8E, 8'h86, 8'h08, 8'h83});

    do_reset({5'h09, 5'h07, 5'h06, 5'h04});
    for (int n = 1; n <= 16; n++) step_check(n, {8'h90, 8'hF8, 8'h82, 8'h99});

`ifdef SEVENSEG_LZ_BLANK_EN
    lz_hex = {8'hFF, 8'h7F, 8'h92, 8'hC0};
`else
    lz_hex = {8'hC0, 8'h40, 8'h92, 8'hC0};
`endif
    do_reset({5'h00, 5'h10, 5'h05, 5'h00});
    for (int n = 1; n <= 16; n++) step_check(n, lz_hex);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_mux.md
# seven_seg_scan_mux

Parametrised time-multiplexed seven-segment display driver for the board's common-anode display bank. Selects one of NUM_DIGITS 5-bit digit codes (4-bit hex value plus decimal point) per scan slot, decodes it to active-low segments, and strobes the matching active-low digit select. A frame buffer is reloaded only at frame boundaries, so a digit value never changes partway through a frame. Sits between the display-value producers (counters, register views) and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 2..8
- REFRESH_DIV, 100000, CLK cycles per scan slot; legal >= 2
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  1  1 = scan runs; 0 = prescaler holds and display blanks
- DIGITS_IN  input  5*NUM_DIGITS  digit k at [5k+4:5k]; bit 4 = DP lit, [3:0] = hex value; digit NUM_DIGITS-1 is most significant
- SEG_SELECT_OUT  output  NUM_DIGITS  active-low digit strobe, one-hot-low while scanning
- HEX_OUT  output  8  active-low segments {DP,g,f,e,d,c,b,a}
- SCAN_TICK  output  1  one-cycle pulse on each slot advance

## Operation
- Prescaler counts 0..REFRESH_DIV-1 while ENABLE=1. A tick occurs in the cycle where count = REFRESH_DIV-1; the count then wraps to 0.
- The digit index (0..NUM_DIGITS-1) advances on each tick and wraps from NUM_DIGITS-1 to 0.
- Frame buffer (5*NUM_DIGITS bits):
  - Loads DIGITS_IN on the tick that wraps the index to 0.
  - Also loads DIGITS_IN in the first ENABLE=1 cycle after reset.
  - At all other times it holds.
- Outputs are registered and driven from the frame buffer entry at the current index:
  - SEG_SELECT_OUT = all ones with bit[index] cleared.
  - HEX_OUT[7] = ~DP.
  - HEX_OUT[6:0] = decode of the hex value:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- ENABLE=0:
  - Prescaler and index hold.
  - From the next edge, SEG_SELECT_OUT is all ones and HEX_OUT = 8'hFF.
  - Resuming ENABLE=1 continues from the held count and index.
- SCAN_TICK is a registered copy of the internal tick.

## Timing
- Reset values: prescaler 0, index 0, frame buffer 0, SEG_SELECT_OUT all ones, HEX_OUT 8'hFF, SCAN_TICK 0.
- RESET has priority over ENABLE. A RESET in any cycle, including mid-slot or mid-frame, restores all reset values at that edge.
- Latency: outputs reflect a new index, or newly loaded buffer data, one edge after the tick edge. SCAN_TICK rises on that same edge.
- First display after reset with ENABLE=1:
  - SEG_SELECT_OUT drives digit 0 from the first edge after ENABLE is sampled high.
  - Each digit is then held for exactly REFRESH_DIV cycles.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- A DIGITS_IN change mid-frame is invisible until the next wrap-to-0 tick.
- A DIGITS_IN change on the wrap tick cycle itself is captured.

## Configuration
- SEVENSEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Digit k (k > 0) is blanked (HEX_OUT[6:0] = 7'h7F) when its hex value and the hex values of all digits above it in the frame buffer are 0.
  - DP is still shown on blanked digits.
  - Digit 0 is never blanked.
  - Select strobing is unchanged.
- SEVENSEG_LZ_BLANK_EN undefined: all digits are always decoded; no blanking logic is synthesised.

## Test plan
1. **Reset.** NUM_DIGITS=4, REFRESH_DIV=4; assert RESET with ENABLE=1 -> SEG_SELECT_OUT=4'b1111, HEX_OUT=8'hFF, SCAN_TICK=0.
2. **Basic scan.** DIGITS_IN={5'h03,5'h02,5'h11,5'h00}; release RESET.
   - SEG_SELECT_OUT = 1110, 1101, 1011, 0111, repeating every 16 cycles, 4 cycles each.
   - HEX_OUT = C0, 79, A4, B0 (digit 1 has DP lit, so 79 = 8'h79).
3. **Frame-boundary reload.** Change DIGITS_IN to all 5'h08 while digit 1 is displayed -> digits 2–3 still show the old values; next frame shows HEX_OUT=8'h80 on every digit.
4. **Enable gating.** Drop ENABLE mid-slot for 10 cycles -> outputs go all ones / 8'hFF next edge and no SCAN_TICK occurs; on re-enable, the same digit completes its remaining slot cycles.
5. **Mid-frame reset.** Assert RESET while digit 2 is displayed -> reset values at the next edge; after release the scan restarts at digit 0 with a fresh buffer load.
6. **Leading-zero blanking** (SEVENSEG_LZ_BLANK_EN defined). DIGITS_IN={5'h00,5'h10,5'h05,5'h00}:
   - Digit 3 -> HEX_OUT=8'hFF.
   - Digit 2 -> HEX_OUT=8'h7F (blanked, DP lit).
   - Digit 1 -> HEX_OUT=8'h92.
   - Digit 0 -> HEX_OUT=8'hC0.
   - With the macro undefined, digits 3 and 2 show 8'hC0 and 8'h40.
